// File: rtl/mp_sweep_scheduler_if.sv
// Signal bundle between the sweep scheduler (slave) and the datapath side driving
// x_initial / candidate rows / betas and consuming the issue strobes (master).
interface mp_sweep_scheduler_if #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 2
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;
    localparam int I_WIDTH = $clog2(I) + 1;

    // Handshake: every *_tvalid input is a valid-only beat consumed in the cycle it is
    // sampled high (there is no ready); the only back-pressure is ds_almost_full, which
    // holds off start_gen. start_gen, J_idx_tvalid and done are single-cycle pulses.
    logic               x_initial_tvalid;
    logic               candidate_row_tvalid;
    logic               candidate_row_tlast;
    logic               ds_almost_full;
    logic               beta_tvalid;
    logic               start_gen;
    logic [J_WIDTH-1:0] J_idx;
    logic               J_idx_tvalid;
    logic [A_WIDTH-1:0] A_value;
    logic [I_WIDTH-1:0] I_idx;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         dbg_state;

    modport master (
        output x_initial_tvalid, candidate_row_tvalid, candidate_row_tlast,
               ds_almost_full, beta_tvalid,
        input  start_gen, J_idx, J_idx_tvalid, A_value, I_idx, busy, done, err, dbg_state
    );

    modport slave (
        input  x_initial_tvalid, candidate_row_tvalid, candidate_row_tlast,
               ds_almost_full, beta_tvalid,
        output start_gen, J_idx, J_idx_tvalid, A_value, I_idx, busy, done, err, dbg_state
    );
endinterface

// File: rtl/mp_sweep_scheduler.sv
// Walks the (I_idx, J_idx, A_value) loop nest once per x_initial, issuing one start_gen
// per (j, a) block and closing each outer iteration after J betas have returned.
module mp_sweep_scheduler #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mp_sweep_scheduler_if.slave  bus
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;
    localparam int I_WIDTH = $clog2(I) + 1;

    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(J - 1);
    localparam logic [J_WIDTH-1:0] J_FULL = J_WIDTH'(J);
    localparam logic [A_WIDTH-1:0] A_LAST = A_WIDTH'(A - 1);
    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(I - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ROW  = 3'd2,
        S_WAIT_BETA = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [J_WIDTH-1:0] r_j_idx, w_j_idx_nxt;
    logic [A_WIDTH-1:0] r_a_value, w_a_value_nxt;
    logic [I_WIDTH-1:0] r_i_idx, w_i_idx_nxt;
    logic [J_WIDTH-1:0] r_beta_cnt, w_beta_cnt_nxt;
    logic               r_start_gen, w_start_gen_nxt;
    logic               r_j_idx_tvalid, w_j_idx_tvalid_nxt;
    logic               r_done, w_done_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_err, w_err_nxt;

    logic               w_row_last;
    logic               w_beta_inc;
    logic [J_WIDTH-1:0] w_beta_total;

    assign w_row_last = bus.candidate_row_tvalid & bus.candidate_row_tlast;
    // Betas are counted from ISSUE onward because the MAC may finish columns before the
    // last block of the iteration has been issued; a beta beyond J is dropped.
    assign w_beta_inc   = bus.beta_tvalid && (r_state != S_IDLE) && (r_beta_cnt != J_FULL);
    assign w_beta_total = r_beta_cnt + J_WIDTH'(w_beta_inc);

    always_comb begin
        w_state_nxt        = r_state;
        w_j_idx_nxt        = r_j_idx;
        w_a_value_nxt      = r_a_value;
        w_i_idx_nxt        = r_i_idx;
        w_beta_cnt_nxt     = (r_state != S_IDLE) ? w_beta_total : r_beta_cnt;
        w_start_gen_nxt    = 1'b0;
        w_j_idx_tvalid_nxt = 1'b0;
        w_done_nxt         = 1'b0;
        w_err_nxt          = r_err;

        if (bus.x_initial_tvalid && (r_state != S_IDLE))
            w_err_nxt = 1'b1;
        if (w_row_last && (r_state != S_WAIT_ROW))
            w_err_nxt = 1'b1;
        if (bus.beta_tvalid && ((r_state == S_IDLE) || (r_beta_cnt == J_FULL)))
            w_err_nxt = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (bus.x_initial_tvalid) begin
                    w_i_idx_nxt        = '0;
                    w_j_idx_nxt        = '0;
                    w_a_value_nxt      = '0;
                    w_beta_cnt_nxt     = '0;
                    w_j_idx_tvalid_nxt = 1'b1;
                    w_state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.ds_almost_full) begin
                    w_start_gen_nxt = 1'b1;
                    w_state_nxt     = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                if (w_row_last) begin
                    if (r_a_value < A_LAST) begin
                        w_a_value_nxt = r_a_value + 1'b1;
                        w_state_nxt   = S_ISSUE;
                    end else if (r_j_idx < J_LAST) begin
                        w_a_value_nxt      = '0;
                        w_j_idx_nxt        = r_j_idx + 1'b1;
                        w_j_idx_tvalid_nxt = 1'b1;
                        w_state_nxt        = S_ISSUE;
                    end else begin
                        w_a_value_nxt = '0;
                        w_state_nxt   = S_WAIT_BETA;
                    end
                end
            end
            S_WAIT_BETA: begin
                if (w_beta_total == J_FULL) begin
                    w_beta_cnt_nxt = '0;
                    if (r_i_idx < I_LAST) begin
                        w_i_idx_nxt        = r_i_idx + 1'b1;
                        w_j_idx_nxt        = '0;
                        w_j_idx_tvalid_nxt = 1'b1;
                        w_state_nxt        = S_ISSUE;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_j_idx        <= '0;
            r_a_value      <= '0;
            r_i_idx        <= '0;
            r_beta_cnt     <= '0;
            r_start_gen    <= 1'b0;
            r_j_idx_tvalid <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_j_idx        <= w_j_idx_nxt;
            r_a_value      <= w_a_value_nxt;
            r_i_idx        <= w_i_idx_nxt;
            r_beta_cnt     <= w_beta_cnt_nxt;
            r_start_gen    <= w_start_gen_nxt;
            r_j_idx_tvalid <= w_j_idx_tvalid_nxt;
            r_done         <= w_done_nxt;
            r_busy         <= w_busy_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign bus.start_gen    = r_start_gen;
    assign bus.J_idx        = r_j_idx;
    assign bus.J_idx_tvalid = r_j_idx_tvalid;
    assign bus.A_value      = r_a_value;
    assign bus.I_idx        = r_i_idx;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_mp_sweep_scheduler.sv
// Directed bench for mp_sweep_scheduler: each task drives one scenario of full sweeps
// and checks pulse counts, issue order, latencies and the error flag.
module tb_mp_sweep_scheduler;
    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int JW = $clog2(J) + 1;
    localparam int AW = $clog2(A) + 1;
    localparam int IW = $clog2(I) + 1;
    localparam int W  = IW + JW + AW;
    localparam int N_SG = I * J * A;
    localparam int N_JV = I * J;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mp_sweep_scheduler_if #(.J(J), .I(I), .A(A)) bus();
    mp_sweep_scheduler #(.J(J), .I(I), .A(A)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Statistics gathered by the sweep driver, checked by the test tasks.
    int cyc;
    int n_sg, n_jv, n_done;
    int seq_bad, lat_bad, stab_bad, spc_bad, bp_viol;
    bit timed_out, aborted;
    logic x_jv, x_busy, post_busy, post_done;
    logic [W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (bus.start_gen === 1'b1) n_sg++;
        if (bus.J_idx_tvalid === 1'b1) n_jv++;
        if (bus.done === 1'b1) n_done++;
    endtask

    task automatic idle_inputs();
        bus.x_initial_tvalid     = 1'b0;
        bus.candidate_row_tvalid = 1'b0;
        bus.candidate_row_tlast  = 1'b0;
        bus.ds_almost_full       = 1'b0;
        bus.beta_tvalid          = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // early_mode: 0 betas after last tlast, 1 all J during last block, 2 J-1 during last
    // block + 1 in first WAIT_BETA cycle, 3 J+1 during last block.
    // err_kind: 2 x_initial mid-sweep, 3 extra tlast in ISSUE. abort_i/j >= 0 stops the
    // sweep when the block (abort_i, abort_j, 0) is issued.
    task automatic run_sweep(input int rows, input int early_mode, input int bp_blk,
                             input int err_kind, input int abort_i, input int abort_j);
        int rows_left = 0, early_left = 0, beta_left = 0, bp_left = 0;
        int blk = 0, cur_blk = 0, last_m, exp_lat = 2, prev_sg = -100, sg_cyc;
        bit in_blk = 0, extra_tlast = 0, send_x = 0, x_sent = 0, first_tlast = 1;
        bit drove_tlast, cur_last = 0, ds_prev, finished = 0;
        logic [JW-1:0] cap_j;
        logic [AW-1:0] cap_a;
        logic [W-1:0]  got, expv;

        n_sg = 0; n_jv = 0; n_done = 0;
        seq_bad = 0; lat_bad = 0; stab_bad = 0; spc_bad = 0; bp_viol = 0;
        timed_out = 0; aborted = 0;
        exp_q.delete();
        for (int i = 0; i < I; i++)
            for (int j = 0; j < J; j++)
                for (int a = 0; a < A; a++)
                    exp_q.push_back({IW'(i), JW'(j), AW'(a)});

        idle_inputs();
        bus.x_initial_tvalid = 1'b1;
        tick();
        bus.x_initial_tvalid = 1'b0;
        last_m = cyc;
        x_jv   = bus.J_idx_tvalid;
        x_busy = bus.busy;

        for (int c = 0; c < 6000; c++) begin
            bus.candidate_row_tvalid = 1'b0;
            bus.candidate_row_tlast  = 1'b0;
            bus.beta_tvalid          = 1'b0;
            bus.x_initial_tvalid     = send_x;
            send_x      = 1'b0;
            drove_tlast = 1'b0;
            if (rows_left > 0) begin
                bus.candidate_row_tvalid = 1'b1;
                if (rows_left == 1) begin
                    bus.candidate_row_tlast = 1'b1;
                    drove_tlast = 1'b1;
                end
                rows_left--;
            end else if (extra_tlast) begin
                bus.candidate_row_tvalid = 1'b1;
                bus.candidate_row_tlast  = 1'b1;
                extra_tlast = 1'b0;
            end
            if (early_left > 0) begin
                bus.beta_tvalid = 1'b1;
                early_left--;
            end else if (beta_left > 0) begin
                bus.beta_tvalid = 1'b1;
                beta_left--;
            end
            bus.ds_almost_full = (bp_left > 0);
            if (bp_left > 0) bp_left--;
            ds_prev = bus.ds_almost_full;
            if (drove_tlast) begin
                if (err_kind == 3 && first_tlast && !cur_last) extra_tlast = 1'b1;
                first_tlast = 1'b0;
                if (cur_last) begin
                    beta_left = (early_mode == 0) ? J : (early_mode == 2) ? 1 : 0;
                    exp_lat   = (early_mode == 0) ? J + 2 : 3;
                    blk = 0;
                end else if (cur_blk == bp_blk && exp_q.size() > N_SG - J * A) begin
                    bp_left = 20;
                    exp_lat = 22;
                end else begin
                    exp_lat = 2;
                end
            end

            tick();

            if (drove_tlast) begin
                last_m = cyc;
                in_blk = 1'b0;
            end else if (in_blk && (bus.J_idx !== cap_j || bus.A_value !== cap_a)) begin
                stab_bad++;
            end
            if (bus.start_gen === 1'b1) begin
                sg_cyc = cyc + 1;
                if (sg_cyc - last_m != exp_lat) lat_bad++;
                if (sg_cyc - prev_sg < 2) spc_bad++;
                prev_sg = sg_cyc;
                if (ds_prev) bp_viol++;
                got = {bus.I_idx, bus.J_idx, bus.A_value};
                if (exp_q.size() == 0) begin
                    seq_bad++;
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) seq_bad++;
                end
                cap_j      = bus.J_idx;
                cap_a      = bus.A_value;
                in_blk     = 1'b1;
                cur_blk    = blk;
                cur_last   = (blk == J * A - 1);
                rows_left  = (cur_last && early_mode != 0) ? 16 : rows;
                early_left = !cur_last ? 0 : (early_mode == 1) ? J :
                             (early_mode == 2) ? J - 1 : (early_mode == 3) ? J + 1 : 0;
                blk++;
                if (err_kind == 2 && !x_sent) begin
                    send_x = 1'b1;
                    x_sent = 1'b1;
                end
                if (abort_i >= 0 && int'(bus.I_idx) == abort_i && int'(bus.J_idx) == abort_j) begin
                    aborted  = 1'b1;
                    finished = 1'b1;
                    break;
                end
            end
            if (bus.done === 1'b1) begin
                idle_inputs();
                tick();
                post_busy = bus.busy;
                post_done = bus.done;
                finished  = 1'b1;
                break;
            end
        end
        idle_inputs();
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (bus.start_gen !== 1'b0) begin tests_failed++; $display("FAIL reset start_gen: got %b exp 0", bus.start_gen); end
        tests_run++; if (bus.J_idx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset J_idx_tvalid: got %b exp 0", bus.J_idx_tvalid); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset done: got %b exp 0", bus.done); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b exp 0", bus.busy); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset err: got %b exp 0", bus.err); end
        tests_run++; if ({bus.I_idx, bus.J_idx, bus.A_value} !== '0) begin tests_failed++; $display("FAIL reset idx: got I=%0d J=%0d A=%0d exp 0", bus.I_idx, bus.J_idx, bus.A_value); end
        tests_run++; if (bus.dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset state: got %0d exp 0", bus.dbg_state); end
        // beta in IDLE is a protocol error but must not start anything
        bus.beta_tvalid = 1'b1;
        tick();
        bus.beta_tvalid = 1'b0;
        tick();
        tests_run++; if (bus.err !== 1'b1) begin tests_failed++; $display("FAIL idle_beta err: got %b exp 1", bus.err); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_beta busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_nominal();
        apply_reset();
        run_sweep(3, 0, -1, 0, -1, -1);
        tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL nominal timeout: got %b exp 0", timed_out); end
        tests_run++; if (x_jv !== 1'b1) begin tests_failed++; $display("FAIL nominal jv_at_n1: got %b exp 1", x_jv); end
        tests_run++; if (x_busy !== 1'b1) begin tests_failed++; $display("FAIL nominal busy_at_n1: got %b exp 1", x_busy); end
        tests_run++; if (n_sg !== N_SG) begin tests_failed++; $display("FAIL nominal n_start_gen: got %0d exp %0d", n_sg, N_SG); end
        tests_run++; if (n_jv !== N_JV) begin tests_failed++; $display("FAIL nominal n_J_idx_tvalid: got %0d exp %0d", n_jv, N_JV); end
        tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL nominal n_done: got %0d exp 1", n_done); end
        tests_run++; if (seq_bad !== 0 || exp_q.size() !== 0) begin tests_failed++; $display("FAIL nominal sequence: bad=%0d left=%0d exp 0/0", seq_bad, exp_q.size()); end
        tests_run++; if (lat_bad !== 0) begin tests_failed++; $display("FAIL nominal latency: bad=%0d exp 0", lat_bad); end
        tests_run++; if (stab_bad !== 0) begin tests_failed++; $display("FAIL nominal stability: bad=%0d exp 0", stab_bad); end
        tests_run++; if (spc_bad !== 0) begin tests_failed++; $display("FAIL nominal spacing: bad=%0d exp 0", spc_bad); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL nominal err: got %b exp 0", bus.err); end
        tests_run++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin tests_failed++; $display("FAIL nominal after_done: busy=%b done=%b exp 0/0", post_busy, post_done); end
        tests_run++; if (bus.I_idx !== IW'(I - 1) || bus.J_idx !== JW'(J - 1) || bus.A_value !== AW'(0)) begin
            tests_failed++; $display("FAIL nominal final_idx: got I=%0d J=%0d A=%0d exp %0d/%0d/0", bus.I_idx, bus.J_idx, bus.A_value, I - 1, J - 1);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_sweep(1, 0, -1, 0, -1, -1);
        tests_run++; if (n_sg !== N_SG) begin tests_failed++; $display("FAIL b2b n_start_gen: got %0d exp %0d", n_sg, N_SG); end
        tests_run++; if (seq_bad !== 0) begin tests_failed++; $display("FAIL b2b sequence: bad=%0d exp 0", seq_bad); end
        tests_run++; if (lat_bad !== 0) begin tests_failed++; $display("FAIL b2b latency: bad=%0d exp 0", lat_bad); end
        tests_run++; if (spc_bad !== 0) begin tests_failed++; $display("FAIL b2b spacing: bad=%0d exp 0", spc_bad); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL b2b err: got %b exp 0", bus.err); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_sweep(3, 0, 3, 0, -1, -1);
        tests_run++; if (bp_viol !== 0) begin tests_failed++; $display("FAIL bp issue_while_full: got %0d exp 0", bp_viol); end
        tests_run++; if (lat_bad !== 0) begin tests_failed++; $display("FAIL bp latency: bad=%0d exp 0", lat_bad); end
        tests_run++; if (n_sg !== N_SG || seq_bad !== 0) begin tests_failed++; $display("FAIL bp pulses: got n=%0d bad=%0d exp %0d/0", n_sg, seq_bad, N_SG); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL bp err: got %b exp 0", bus.err); end
    endtask

    task automatic test_early_beta();
        apply_reset();
        run_sweep(3, 1, -1, 0, -1, -1);
        tests_run++; if (lat_bad !== 0) begin tests_failed++; $display("FAIL early latency: bad=%0d exp 0", lat_bad); end
        tests_run++; if (n_sg !== N_SG || seq_bad !== 0) begin tests_failed++; $display("FAIL early sequence: n=%0d bad=%0d exp %0d/0", n_sg, seq_bad, N_SG); end
        tests_run++; if (n_done !== 1 || bus.err !== 1'b0) begin tests_failed++; $display("FAIL early done_err: done=%0d err=%b exp 1/0", n_done, bus.err); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        run_sweep(3, 2, -1, 0, -1, -1);
        tests_run++; if (lat_bad !== 0) begin tests_failed++; $display("FAIL samecyc latency: bad=%0d exp 0", lat_bad); end
        tests_run++; if (n_sg !== N_SG || seq_bad !== 0) begin tests_failed++; $display("FAIL samecyc sequence: n=%0d bad=%0d exp %0d/0", n_sg, seq_bad, N_SG); end
        tests_run++; if (n_done !== 1 || bus.err !== 1'b0) begin tests_failed++; $display("FAIL samecyc done_err: done=%0d err=%b exp 1/0", n_done, bus.err); end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            case (k)
                0:       run_sweep(3, 3, -1, 0, -1, -1);
                1:       run_sweep(3, 0, -1, 2, -1, -1);
                default: run_sweep(3, 0, -1, 3, -1, -1);
            endcase
            tests_run++; if (bus.err !== 1'b1) begin tests_failed++; $display("FAIL err%0d flag: got %b exp 1", k, bus.err); end
            tests_run++; if (n_sg !== N_SG || seq_bad !== 0) begin tests_failed++; $display("FAIL err%0d sequence: n=%0d bad=%0d exp %0d/0", k, n_sg, seq_bad, N_SG); end
            tests_run++; if (n_done !== 1 || lat_bad !== 0) begin tests_failed++; $display("FAIL err%0d done_lat: done=%0d latbad=%0d exp 1/0", k, n_done, lat_bad); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_sweep(3, 0, -1, 0, 3, 5);
        tests_run++; if (aborted !== 1'b1) begin tests_failed++; $display("FAIL rstmid reached: got %b exp 1", aborted); end
        rst = 1'b1;
        bus.candidate_row_tvalid = 1'b1;
        bus.candidate_row_tlast  = 1'b1;
        bus.beta_tvalid          = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        tests_run++; if ({bus.start_gen, bus.J_idx_tvalid, bus.done, bus.busy, bus.err} !== 5'b0) begin
            tests_failed++; $display("FAIL rstmid flags: got sg=%b jv=%b done=%b busy=%b err=%b exp 0", bus.start_gen, bus.J_idx_tvalid, bus.done, bus.busy, bus.err);
        end
        tests_run++; if ({bus.I_idx, bus.J_idx, bus.A_value} !== '0 || bus.dbg_state !== 3'd0) begin
            tests_failed++; $display("FAIL rstmid idx: got I=%0d J=%0d A=%0d st=%0d exp 0", bus.I_idx, bus.J_idx, bus.A_value, bus.dbg_state);
        end
        tick();
        tick();
        tests_run++; if (bus.busy !== 1'b0 || bus.start_gen !== 1'b0) begin tests_failed++; $display("FAIL rstmid stays_idle: busy=%b sg=%b exp 0/0", bus.busy, bus.start_gen); end
        run_sweep(3, 0, -1, 0, -1, -1);
        tests_run++; if (n_sg !== N_SG || seq_bad !== 0) begin tests_failed++; $display("FAIL rstmid restart: n=%0d bad=%0d exp %0d/0", n_sg, seq_bad, N_SG); end
        tests_run++; if (n_done !== 1 || bus.err !== 1'b0) begin tests_failed++; $display("FAIL rstmid restart_done: done=%0d err=%b exp 1/0", n_done, bus.err); end
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0;
        idle_inputs();
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_early_beta();
        test_same_cycle();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
